// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the four-digit BCD stopwatch (SS.hh).
package stopwatch_pkg;

  localparam int unsigned TICK_DIV_DEFAULT        = 1_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 2_000_000;
  localparam int unsigned DIGITS                  = 4;
  localparam int unsigned DIGITS_W                = 4 * DIGITS;
  localparam logic [3:0]  BCD_MAX                 = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  // BCD ripple increment; MSB of the result is the carry out of the top digit.
  function automatic logic [DIGITS_W:0] bcd_inc(input logic [DIGITS_W-1:0] v);
    logic [DIGITS_W-1:0] r;
    logic                c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (c) begin
        if (v[4*i +: 4] == BCD_MAX) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-level filter, rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept_c;

  // The synchronised level must differ from the accepted one for DEBOUNCE_CYCLES cycles.
  assign accept_c = (sync2_q != level_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      pulse   <= accept_c && sync2_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (accept_c) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch SS.hh with start/stop and clear buttons.
// Lap hold on btn_lap is built only when STOPWATCH_LAP_EN is defined.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV        = TICK_DIV_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_start_stop,
  input  logic                btn_clear,
  input  logic                btn_lap,
  output logic [DIGITS_W-1:0] digits,
  output logic                running,
  output logic                overflow
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV + 1);

  state_t              state_q;
  state_t              state_d;
  logic                ss_p;
  logic                clr_p;
  logic                clear_c;
  logic                tick_c;
  logic [DIGITS_W:0]   inc_c;
  logic [PRE_W-1:0]    presc_q;
  logic [DIGITS_W-1:0] count_q;
  logic [DIGITS_W-1:0] digits_q;
  logic                running_q;
  logic                overflow_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_start_stop),
    .pulse (ss_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_clear),
    .pulse (clr_p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Clear beats start/stop outside RUN; inside RUN clear is ignored.
  always_comb begin
    state_d = state_q;
    clear_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_p)     clear_c = 1'b1;
        else if (ss_p) state_d = RUN;
      end
      RUN: begin
        if (ss_p) state_d = PAUSE;
      end
      PAUSE: begin
        if (clr_p) begin
          clear_c = 1'b1;
          state_d = IDLE;
        end else if (ss_p) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tick_c = (state_q == RUN) && (presc_q == PRE_W'(TICK_DIV - 1));
  assign inc_c  = bcd_inc(count_q);

  // Prescaler, live BCD count and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      running_q <= (state_d == RUN);
      if (clear_c) begin
        presc_q    <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else if (state_q == RUN) begin
        if (tick_c) begin
          presc_q <= '0;
          count_q <= inc_c[DIGITS_W-1:0];
          if (inc_c[DIGITS_W]) overflow_q <= 1'b1;
        end else begin
          presc_q <= presc_q + PRE_W'(1);
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_p;
  logic hold_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lap),
    .pulse (lap_p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         hold_q <= 1'b0;
    else if (clear_c)                  hold_q <= 1'b0;
    else if (lap_p && state_q == RUN)  hold_q <= ~hold_q;
  end

  // The edge that sets the hold still loads the display, capturing the lap value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        digits_q <= '0;
    else if (!hold_q) digits_q <= count_q;
  end
`else
  logic unused_lap;
  assign unused_lap = btn_lap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) digits_q <= '0;
    else       digits_q <= count_q;
  end
`endif

  assign digits   = digits_q;
  assign running  = running_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch with TICK_DIV=4, DEBOUNCE_CYCLES=2.
module tb_bcd_stopwatch;

  logic        clk;
  logic        reset;
  logic        btn_start_stop;
  logic        btn_clear;
  logic        btn_lap;
  logic [15:0] digits;
  logic        running;
  logic        overflow;

  int checks;
  int failures;

`ifdef STOPWATCH_LAP_EN
  localparam logic [15:0] LAP_E200 = 16'h0042;
  localparam logic [15:0] LAP_E205 = 16'h0042;
  localparam logic [15:0] LAP_E207 = 16'h0042;
`else
  localparam logic [15:0] LAP_E200 = 16'h0048;
  localparam logic [15:0] LAP_E205 = 16'h0049;
  localparam logic [15:0] LAP_E207 = 16'h0050;
`endif

  bcd_stopwatch #(.TICK_DIV(4), .DEBOUNCE_CYCLES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .btn_lap        (btn_lap),
    .digits         (digits),
    .running        (running),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    tick(3);
    checks++;
    if (digits !== 16'h0000 || running !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got digits=%h running=%b overflow=%b, want 0000/0/0", digits, running, overflow);
    end
    reset = 1'b0;
    tick(4);
    checks++;
    if (digits !== 16'h0000 || running !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got digits=%h running=%b, want 0000/0", digits, running);
    end
  endtask

  // Start at edge k: RUN from k+5, count n lands at k+5+4n, visible one edge later.
  task automatic test_count();
    btn_start_stop = 1'b1;
    tick(4);
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL start_latency_early: got running=%b, want 0", running);
    end
    tick(1);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL start_latency: got running=%b, want 1", running);
    end
    tick(35);
    btn_start_stop = 1'b0;
    tick(5);
    checks++;
    if (digits !== 16'h0009) begin
      failures++;
      $display("FAIL count_0009: got %h, want 0009", digits);
    end
    tick(1);
    checks++;
    if (digits !== 16'h0010) begin
      failures++;
      $display("FAIL bcd_carry_0010: got %h, want 0010", digits);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (digits === 16'h0123) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_0123: timeout, digits=%h want 0123", digits);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (digits !== 16'h0000 || running !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got digits=%h running=%b overflow=%b, want 0000/0/0", digits, running, overflow);
    end
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_glitch();
    btn_start_stop = 1'b1;
    tick(1);
    btn_start_stop = 1'b0;
    tick(20);
    checks++;
    if (running !== 1'b0 || digits !== 16'h0000) begin
      failures++;
      $display("FAIL glitch_rejected: got running=%b digits=%h, want 0/0000", running, digits);
    end
  endtask

  // Pause lands on the 10th terminal-count edge, which still increments.
  task automatic test_pause_clear();
    btn_start_stop = 1'b1;
    tick(4);
    btn_start_stop = 1'b0;
    tick(36);
    btn_start_stop = 1'b1;
    btn_clear      = 1'b1;
    tick(4);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL pause_latency_early: got running=%b, want 1", running);
    end
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    tick(1);
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL pause_wins: got running=%b, want 0", running);
    end
    tick(20);
    checks++;
    if (digits !== 16'h0010) begin
      failures++;
      $display("FAIL pause_hold: got %h, want 0010", digits);
    end
    btn_clear = 1'b1;
    tick(4);
    btn_clear = 1'b0;
    tick(10);
    checks++;
    if (digits !== 16'h0000 || running !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL clear_from_pause: got digits=%h running=%b overflow=%b, want 0000/0/0", digits, running, overflow);
    end
  endtask

  task automatic test_lap();
    btn_start_stop = 1'b1;
    tick(4);
    btn_start_stop = 1'b0;
    tick(167);
    btn_lap = 1'b1;
    tick(3);
    btn_lap = 1'b0;
    tick(26);
    checks++;
    if (digits !== LAP_E200) begin
      failures++;
      $display("FAIL lap_hold_e200: got %h, want %h", digits, LAP_E200);
    end
    tick(2);
    btn_lap = 1'b1;
    tick(3);
    btn_lap = 1'b0;
    checks++;
    if (digits !== LAP_E205) begin
      failures++;
      $display("FAIL lap_hold_e205: got %h, want %h", digits, LAP_E205);
    end
    tick(2);
    checks++;
    if (digits !== LAP_E207) begin
      failures++;
      $display("FAIL lap_release_edge: got %h, want %h", digits, LAP_E207);
    end
    tick(1);
    checks++;
    if (digits !== 16'h0050) begin
      failures++;
      $display("FAIL lap_live_0050: got %h, want 0050", digits);
    end
    btn_start_stop = 1'b1;
    tick(4);
    btn_start_stop = 1'b0;
    tick(4);
    btn_clear = 1'b1;
    tick(4);
    btn_clear = 1'b0;
    tick(10);
    checks++;
    if (digits !== 16'h0000 || running !== 1'b0) begin
      failures++;
      $display("FAIL lap_cleanup: got digits=%h running=%b, want 0000/0", digits, running);
    end
  endtask

  task automatic test_overflow();
    bit found;
    found = 1'b0;
    btn_start_stop = 1'b1;
    tick(4);
    btn_start_stop = 1'b0;
    for (int i = 0; i < 45000; i++) begin
      tick(1);
      if (digits === 16'h9999) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reach_9999: timeout, digits=%h want 9999", digits);
    end
    tick(2);
    checks++;
    if (digits !== 16'h9999 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL pre_wrap: got digits=%h overflow=%b, want 9999/0", digits, overflow);
    end
    tick(1);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set: got %b, want 1", overflow);
    end
    tick(1);
    checks++;
    if (digits !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_0000: got %h, want 0000", digits);
    end
    tick(8);
    checks++;
    if (digits !== 16'h0002 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: got digits=%h overflow=%b, want 0002/1", digits, overflow);
    end
    btn_start_stop = 1'b1;
    tick(4);
    btn_start_stop = 1'b0;
    tick(6);
    checks++;
    if (running !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_in_pause: got running=%b overflow=%b, want 0/1", running, overflow);
    end
    btn_clear = 1'b1;
    tick(4);
    btn_clear = 1'b0;
    tick(6);
    checks++;
    if (overflow !== 1'b0 || digits !== 16'h0000) begin
      failures++;
      $display("FAIL overflow_cleared: got overflow=%b digits=%h, want 0/0000", overflow, digits);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_count();
    test_async_reset();
    test_glitch();
    test_pause_clear();
    test_lap();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
